// File: rtl/snake_line_renderer.sv
// snake_line_renderer: builds one playfield row per request.
// The body store is walked node by node. Apple and body cells are ORed into a
// back buffer, which is then swapped to the front buffer in a single cycle.
// The front buffer holds still between line_valid pulses, so the scan-out
// side can read it at any time.
module snake_line_renderer #(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int MAX_NODES = 16,
    parameter int CW        = 6,
    parameter int NW        = $clog2(MAX_NODES)
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              line_req,
    input  logic [CW-1:0]     line_y,
    input  logic [NW:0]       length,
    input  logic              apple_en,
    input  logic [CW-1:0]     apple_x,
    input  logic [CW-1:0]     apple_y,
    output logic [NW-1:0]     node_idx,
    input  logic [CW-1:0]     node_x,
    input  logic [CW-1:0]     node_y,
    output logic [GRID_W-1:0] line_vram,
    output logic              line_valid,
    output logic              busy,
    output logic              head_on_line,
    output logic              apple_hit,
    output logic              overrun
);

    localparam logic [CW:0] GRID_W_C = (CW+1)'(GRID_W);
    localparam logic [CW:0] GRID_H_C = (CW+1)'(GRID_H);
    localparam logic [NW:0] MAX_L_C  = (NW+1)'(MAX_NODES);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, SWAP} state_t;

    // One-hot row mask for column x; an all-zero mask when en is low.
    function automatic logic [GRID_W-1:0] cell_mask(input logic [CW-1:0] x, input logic en);
        logic [GRID_W-1:0] m;
        m = '0;
        for (int i = 0; i < GRID_W; i++) begin
            if (en && (x == CW'(i))) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    state_t            state_r;
    logic [CW-1:0]     line_y_r;
    logic [CW-1:0]     apple_x_r;
    logic              apple_row_r;
    logic              row_ok_r;
    logic [NW:0]       len_r;
    logic [GRID_W-1:0] back_r;
    logic              pend_r;
    logic              pend_head_r;
    logic              head_r;
    logic              hit_r;

    logic [NW:0] eff_len_s;
    logic        row_ok_s;
    logic        apple_row_s;
    logic        node_on_row_s;
    logic        node_x_ok_s;
    logic        last_idx_s;

    // The effective length saturates at the store depth. Rows past the playfield
    // bottom and off-grid apples contribute nothing.
    assign eff_len_s     = (length > MAX_L_C) ? MAX_L_C : length;
    assign row_ok_s      = ({1'b0, line_y} < GRID_H_C);
    assign apple_row_s   = apple_en && (apple_y == line_y) && ({1'b0, apple_x} < GRID_W_C) && row_ok_s;
    assign node_on_row_s = pend_r && row_ok_r && (node_y == line_y_r);
    assign node_x_ok_s   = ({1'b0, node_x} < GRID_W_C);
    assign last_idx_s    = ({1'b0, node_idx} == (len_r - (NW+1)'(1)));

    // Render FSM: captures the request, walks the body store, accumulates cells and swaps buffers.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            line_y_r     <= '0;
            apple_x_r    <= '0;
            apple_row_r  <= 1'b0;
            row_ok_r     <= 1'b0;
            len_r        <= '0;
            back_r       <= '0;
            pend_r       <= 1'b0;
            pend_head_r  <= 1'b0;
            head_r       <= 1'b0;
            hit_r        <= 1'b0;
            node_idx     <= '0;
            line_vram    <= '0;
            line_valid   <= 1'b0;
            busy         <= 1'b0;
            head_on_line <= 1'b0;
            apple_hit    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            line_valid  <= 1'b0;
            pend_r      <= 1'b0;
            pend_head_r <= 1'b0;

            if (line_req && (state_r != IDLE)) begin
                overrun <= 1'b1;
            end else begin
                overrun <= overrun;
            end

            // A store read issued last cycle returns now; fold it into the back buffer.
            if (pend_r) begin
                back_r <= back_r | cell_mask(node_x, node_on_row_s && node_x_ok_s);
                if (pend_head_r) begin
                    head_r <= node_on_row_s;
                    hit_r  <= node_on_row_s && apple_row_r && (node_x == apple_x_r);
                end else begin
                    head_r <= head_r;
                    hit_r  <= hit_r;
                end
            end else begin
                back_r <= back_r;
            end

            case (state_r)
                IDLE: begin
                    if (line_req) begin
                        line_y_r    <= line_y;
                        apple_x_r   <= apple_x;
                        apple_row_r <= apple_row_s;
                        row_ok_r    <= row_ok_s;
                        len_r       <= eff_len_s;
                        back_r      <= cell_mask(apple_x, apple_row_s);
                        head_r      <= 1'b0;
                        hit_r       <= 1'b0;
                        busy        <= 1'b1;
                        // An empty body still takes the drain cycle, so every row keeps the same pipeline shape.
                        state_r     <= (eff_len_s != '0) ? ISSUE : DRAIN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    pend_r      <= 1'b1;
                    pend_head_r <= (node_idx == '0);
                    if (last_idx_s) begin
                        state_r <= DRAIN;
                    end else begin
                        node_idx <= node_idx + NW'(1);
                    end
                end
                DRAIN: begin
                    state_r <= SWAP;
                end
                SWAP: begin
                    line_vram    <= back_r;
                    head_on_line <= head_r;
                    apple_hit    <= hit_r;
                    line_valid   <= 1'b1;
                    busy         <= 1'b0;
                    node_idx     <= '0;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_line_renderer.sv
// Directed bench for snake_line_renderer. A small synchronous RAM model serves
// the body store. Expected rows and edge numbers are hand-computed constants.
module tb_snake_line_renderer;

    logic        clk_50MHz = 1'b0;
    logic        rst;
    logic        line_req;
    logic [5:0]  line_y;
    logic [4:0]  length;
    logic        apple_en;
    logic [5:0]  apple_x;
    logic [5:0]  apple_y;
    logic [3:0]  node_idx;
    logic [5:0]  node_x;
    logic [5:0]  node_y;
    logic [39:0] line_vram;
    logic        line_valid;
    logic        busy;
    logic        head_on_line;
    logic        apple_hit;
    logic        overrun;

    logic [5:0] mem_x [16];
    logic [5:0] mem_y [16];

    int checks = 0;
    int errors = 0;

    snake_line_renderer dut (
        .clk_50MHz    (clk_50MHz),
        .rst          (rst),
        .line_req     (line_req),
        .line_y       (line_y),
        .length       (length),
        .apple_en     (apple_en),
        .apple_x      (apple_x),
        .apple_y      (apple_y),
        .node_idx     (node_idx),
        .node_x       (node_x),
        .node_y       (node_y),
        .line_vram    (line_vram),
        .line_valid   (line_valid),
        .busy         (busy),
        .head_on_line (head_on_line),
        .apple_hit    (apple_hit),
        .overrun      (overrun)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    // Body store: read data appears one cycle after the address.
    always @(posedge clk_50MHz) begin
        node_x <= mem_x[node_idx];
        node_y <= mem_y[node_idx];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_node(input int k, input logic [5:0] x, input logic [5:0] y);
        mem_x[k] = x;
        mem_y[k] = y;
    endtask

    // Pulse line_req (edge 0), scramble the inputs, then report the edge of line_valid
    // (-1 on timeout) and which indices appeared on node_idx while busy.
    task automatic run(output int e_n, output logic [15:0] idx_mask);
        @(negedge clk_50MHz);
        line_req = 1'b1;
        @(posedge clk_50MHz);
        #1;
        line_req = 1'b0;
        line_y   = 6'd63;
        length   = 5'd0;
        apple_en = 1'b0;
        apple_x  = 6'd0;
        apple_y  = 6'd0;
        e_n      = -1;
        idx_mask = 16'h0000;
        if (busy) idx_mask[node_idx] = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk_50MHz);
            #1;
            if (busy) idx_mask[node_idx] = 1'b1;
            if (line_valid === 1'b1) begin
                e_n = e;
                break;
            end
        end
    endtask

    initial begin
        int          e_n;
        int          first_e;
        int          n_valid;
        logic [15:0] m;

        rst = 1'b1; line_req = 1'b0; line_y = 6'd0; length = 5'd0;
        apple_en = 1'b0; apple_x = 6'd0; apple_y = 6'd0;
        for (int k = 0; k < 16; k++) set_node(k, 6'd63, 6'd63);
        repeat (3) @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        rst = 1'b0;
        #1;
        check("rst_vram",  64'(line_vram),    64'h0);
        check("rst_valid", 64'(line_valid),   64'h0);
        check("rst_busy",  64'(busy),         64'h0);
        check("rst_idx",   64'(node_idx),     64'h0);
        check("rst_head",  64'(head_on_line), 64'h0);
        check("rst_hit",   64'(apple_hit),    64'h0);
        check("rst_ovr",   64'(overrun),      64'h0);

        // Three body cells plus the apple on row 10.
        set_node(0, 6'd5, 6'd10); set_node(1, 6'd6, 6'd10); set_node(2, 6'd7, 6'd10);
        line_y = 6'd10; length = 5'd3; apple_en = 1'b1; apple_x = 6'd20; apple_y = 6'd10;
        run(e_n, m);
        check("t1_edge", 64'(e_n),          64'd5);
        check("t1_vram", 64'(line_vram),    64'h1000E0);
        check("t1_head", 64'(head_on_line), 64'h1);
        check("t1_hit",  64'(apple_hit),    64'h0);
        check("t1_busy", 64'(busy),         64'h0);
        check("t1_idx",  64'(m),            64'h0007);
        @(posedge clk_50MHz); #1;
        check("t1_pulse",  64'(line_valid), 64'h0);
        check("t1_stable", 64'(line_vram),  64'h1000E0);

        // Head on the apple: a hit on row 10, nothing on row 11.
        set_node(0, 6'd20, 6'd10);
        line_y = 6'd10; length = 5'd1; apple_en = 1'b1; apple_x = 6'd20; apple_y = 6'd10;
        run(e_n, m);
        check("t2_edge", 64'(e_n),          64'd3);
        check("t2_vram", 64'(line_vram),    64'h100000);
        check("t2_hit",  64'(apple_hit),    64'h1);
        check("t2_head", 64'(head_on_line), 64'h1);
        line_y = 6'd11; length = 5'd1; apple_en = 1'b1; apple_x = 6'd20; apple_y = 6'd10;
        run(e_n, m);
        check("t2b_vram", 64'(line_vram),    64'h0);
        check("t2b_hit",  64'(apple_hit),    64'h0);
        check("t2b_head", 64'(head_on_line), 64'h0);

        // Empty body: only the apple at x=0.
        line_y = 6'd3; length = 5'd0; apple_en = 1'b1; apple_x = 6'd0; apple_y = 6'd3;
        run(e_n, m);
        check("t3_edge", 64'(e_n),       64'd2);
        check("t3_vram", 64'(line_vram), 64'h1);
        check("t3_idx",  64'(m),         64'h0001);

        // Length saturates at 16; all nodes on row 7 at x=k+2.
        for (int k = 0; k < 16; k++) set_node(k, 6'(k + 2), 6'd7);
        line_y = 6'd7; length = 5'd25; apple_en = 1'b0; apple_x = 6'd0; apple_y = 6'd0;
        run(e_n, m);
        check("t4_edge", 64'(e_n),          64'd18);
        check("t4_idx",  64'(m),            64'hFFFF);
        check("t4_vram", 64'(line_vram),    64'h3FFFC);
        check("t4_head", 64'(head_on_line), 64'h1);

        // Off-grid node and apple dropped; a second request at edge 2 raises overrun.
        set_node(0, 6'd45, 6'd12); set_node(1, 6'd3, 6'd12);
        line_y = 6'd12; length = 5'd2; apple_en = 1'b1; apple_x = 6'd50; apple_y = 6'd12;
        @(negedge clk_50MHz); line_req = 1'b1;
        @(posedge clk_50MHz); #1; line_req = 1'b0;
        @(posedge clk_50MHz);
        @(negedge clk_50MHz); line_req = 1'b1;
        @(posedge clk_50MHz); #1; line_req = 1'b0;
        check("t5_ovr_set", 64'(overrun), 64'h1);
        first_e = -1; n_valid = 0;
        for (int e = 3; e <= 30; e++) begin
            @(posedge clk_50MHz); #1;
            if (line_valid === 1'b1) begin
                n_valid++;
                if (first_e < 0) first_e = e;
            end
        end
        check("t5_edge",     64'(first_e),   64'd4);
        check("t5_nvalid",   64'(n_valid),   64'd1);
        check("t5_vram",     64'(line_vram), 64'h8);
        check("t5_hit",      64'(apple_hit), 64'h0);
        check("t5_ovr_hold", 64'(overrun),   64'h1);

        // Reset at edge 3 aborts the render.
        set_node(0, 6'd5, 6'd10); set_node(1, 6'd6, 6'd10); set_node(2, 6'd7, 6'd10);
        line_y = 6'd10; length = 5'd3; apple_en = 1'b1; apple_x = 6'd20; apple_y = 6'd10;
        @(negedge clk_50MHz); line_req = 1'b1;
        @(posedge clk_50MHz); #1; line_req = 1'b0;
        repeat (3) @(posedge clk_50MHz);
        #1; rst = 1'b1;
        #1;
        check("t6_vram",  64'(line_vram),    64'h0);
        check("t6_busy",  64'(busy),         64'h0);
        check("t6_ovr",   64'(overrun),      64'h0);
        check("t6_idx",   64'(node_idx),     64'h0);
        check("t6_valid", 64'(line_valid),   64'h0);
        check("t6_head",  64'(head_on_line), 64'h0);
        @(negedge clk_50MHz); rst = 1'b0;
        n_valid = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk_50MHz); #1;
            if (line_valid === 1'b1) n_valid++;
        end
        check("t6_novalid", 64'(n_valid), 64'd0);
        line_y = 6'd10; length = 5'd3; apple_en = 1'b1; apple_x = 6'd20; apple_y = 6'd10;
        run(e_n, m);
        check("t6_re_edge", 64'(e_n),       64'd5);
        check("t6_re_vram", 64'(line_vram), 64'h1000E0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
